// File: rtl/hp_mul_pkg.sv
// Shared types and constants for the FP16 multiply sequencer.
// Operand layout, FSM encodings, exception codes and special-operand classifiers.
package hp_mul_pkg;

    localparam int EXP_W       = 5;
    localparam int MAN_W       = 10;
    localparam int ACC_W       = 26;
    localparam int M_W         = 13;
    localparam int BOOTH_STEPS = 6;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] man;
    } hp_t;

    localparam logic [1:0] EXC_NONE    = 2'b00;
    localparam logic [1:0] EXC_OVF     = 2'b01;
    localparam logic [1:0] EXC_UNF     = 2'b10;
    localparam logic [1:0] EXC_INVALID = 2'b11;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CHECK = 3'd1;
    localparam logic [2:0] BOOTH = 3'd2;
    localparam logic [2:0] NORM  = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;

    // Inf/NaN or denormal operands are rejected rather than computed.
    function automatic logic is_special(input hp_t x);
        return (x.exp == '1) || ((x.exp == '0) && (x.man != '0));
    endfunction

    function automatic logic is_zero(input hp_t x);
        return (x.exp == '0) && (x.man == '0);
    endfunction

endpackage

// File: rtl/hp_mul_booth_step.sv
// One radix-4 Booth step: add the recoded multiple of M into the upper field, then shift right by 2.
// Latency: combinational. Backpressure: none, the caller sequences it.
// Recoding window is acc_in[2:0].
module hp_booth_step
    import hp_mul_pkg::*;
(
    input  logic [ACC_W-1:0] acc_in,
    input  logic [M_W-1:0]   m,
    output logic [ACC_W-1:0] acc_out
);

    logic [M_W-1:0] m2;
    logic [M_W-1:0] addend;
    logic [M_W-1:0] sum;

    assign m2 = {m[M_W-2:0], 1'b0};

    always_comb begin
        addend = '0;
        case (acc_in[2:0])
            3'b001, 3'b010: addend = m;
            3'b011:         addend = m2;
            3'b100:         addend = M_W'(0) - m2;
            3'b101, 3'b110: addend = M_W'(0) - m;
            default:        addend = '0;
        endcase
    end

    assign sum     = acc_in[ACC_W-1 -: M_W] + addend;
    assign acc_out = {sum[M_W-1], sum[M_W-1], sum, acc_in[ACC_W-M_W-1:2]};

endmodule

// File: rtl/hp_mul_seq_ctrl.sv
// FP16 multiply sequencer: classify, 6-step radix-4 Booth, normalise/range-check, hold result.
// Latency: 2 cycles for special operands, 9 for normal ones. Result held until out_ready; new pair accepted on the consume edge.
// Optional HP_MUL_ROUND_EN: round-to-nearest-even in NORM instead of truncation.
module hp_mul_seq_ctrl
    import hp_mul_pkg::*;
#(
    parameter int          EXP_BIAS        = 15,
    parameter logic [15:0] INVALID_PAYLOAD = 16'h7E00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] hp_inA,
    input  logic [15:0] hp_inB,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] hp_product,
    output logic [1:0]  Exceptions,
    output logic        busy
);

    logic [2:0]        state_q;
    hp_t               op_a_q, op_b_q;
    logic              sign_q;
    logic signed [6:0] exp_q;
    logic [M_W-1:0]    m_q;
    logic [ACC_W-1:0]  acc_q, acc_next;
    logic [2:0]        cnt_q;
    logic [15:0]       res_q;
    logic [1:0]        exc_q;

    logic              accept;
    logic signed [6:0] exp_sum;
    logic [21:0]       p;
    logic [MAN_W-1:0]  norm_man;
    logic signed [6:0] norm_exp;
    logic [15:0]       norm_res;
    logic [1:0]        norm_exc;
    logic              unused_acc_bits;

    assign in_ready   = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = (state_q == HOLD);
    assign busy       = (state_q != IDLE);
    assign hp_product = res_q;
    assign Exceptions = exc_q;

    assign exp_sum = 7'({2'b00, op_a_q.exp}) + 7'({2'b00, op_b_q.exp}) - 7'(EXP_BIAS);

    hp_booth_step u_booth_step (
        .acc_in  (acc_q),
        .m       (m_q),
        .acc_out (acc_next)
    );

    // After six steps the 22-bit mantissa product sits just above the Booth guard bit.
    assign p               = acc_q[22:1];
    assign unused_acc_bits = ^{acc_q[25:23], acc_q[0]};

    always_comb begin
        norm_man = '0;
        norm_exp = exp_q;
        if (p[21]) begin
            norm_man = p[20:11];
            norm_exp = exp_q + 7'sd1;
        end else begin
            norm_man = p[19:10];
        end
`ifdef HP_MUL_ROUND_EN
        begin
            logic guard_bit;
            logic sticky_bit;
            guard_bit  = p[21] ? p[10] : p[9];
            sticky_bit = p[21] ? (|p[9:0]) : (|p[8:0]);
            if (guard_bit && (sticky_bit || norm_man[0])) begin
                if (&norm_man) begin
                    norm_man = '0;
                    norm_exp = norm_exp + 7'sd1;
                end else begin
                    norm_man = norm_man + 1'b1;
                end
            end
        end
`endif
        if (norm_exp > 7'sd30) begin
            norm_exc = EXC_OVF;
            norm_res = INVALID_PAYLOAD;
        end else if (norm_exp < 7'sd1) begin
            norm_exc = EXC_UNF;
            norm_res = INVALID_PAYLOAD;
        end else begin
            norm_exc = EXC_NONE;
            norm_res = {sign_q, norm_exp[4:0], norm_man};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            m_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            exc_q   <= EXC_NONE;
        end else begin
            if (accept) begin
                op_a_q <= hp_t'(hp_inA);
                op_b_q <= hp_t'(hp_inB);
            end
            case (state_q)
                IDLE: begin
                    if (accept) state_q <= CHECK;
                end
                CHECK: begin
                    if (is_special(op_a_q) || is_special(op_b_q)) begin
                        exc_q   <= EXC_INVALID;
                        res_q   <= INVALID_PAYLOAD;
                        state_q <= HOLD;
                    end else if (is_zero(op_a_q) || is_zero(op_b_q)) begin
                        exc_q   <= EXC_NONE;
                        res_q   <= 16'h0000;
                        state_q <= HOLD;
                    end else begin
                        sign_q  <= op_a_q.sign ^ op_b_q.sign;
                        exp_q   <= exp_sum;
                        m_q     <= {3'b001, op_a_q.man};
                        acc_q   <= {13'b0, 2'b01, op_b_q.man, 1'b0};
                        cnt_q   <= '0;
                        state_q <= BOOTH;
                    end
                end
                BOOTH: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'(BOOTH_STEPS - 1)) state_q <= NORM;
                end
                NORM: begin
                    res_q   <= norm_res;
                    exc_q   <= norm_exc;
                    state_q <= HOLD;
                end
                HOLD: begin
                    if (out_ready) state_q <= accept ? CHECK : IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hp_mul_seq_ctrl.sv
// Directed vector bench for hp_mul_seq_ctrl: table of operand pairs plus backpressure and reset sequences.
// Latency is counted in clock edges with the accepting edge as edge 1.
module tb_hp_mul_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] hp_inA;
    logic [15:0] hp_inB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] hp_product;
    logic [1:0]  Exceptions;
    logic        busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] prod;
        logic [1:0]  exc;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    hp_mul_seq_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .hp_inA     (hp_inA),
        .hp_inB     (hp_inB),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .hp_product (hp_product),
        .Exceptions (Exceptions),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a pair, wait for acceptance, then count edges until out_valid rises.
    task automatic start_op(input logic [15:0] a, input logic [15:0] b, output int lat);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        hp_inA   = a;
        hp_inB   = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [15:0] held_prod;
        logic        stable;
        logic        stale;

        vecs[0] = '{16'h4500, 16'h4600, 16'h4F80, 2'b00, 9};
        vecs[1] = '{16'h4200, 16'h4200, 16'h4880, 2'b00, 9};
        vecs[2] = '{16'hC100, 16'h4400, 16'hC900, 2'b00, 9};
        vecs[3] = '{16'h7C00, 16'h4E66, 16'h7E00, 2'b11, 2};
        vecs[4] = '{16'h0000, 16'h4E66, 16'h0000, 2'b00, 2};
        vecs[5] = '{16'h011E, 16'h4E66, 16'h7E00, 2'b11, 2};
        vecs[6] = '{16'h7BFF, 16'h7BFF, 16'h7E00, 2'b01, 9};
        vecs[7] = '{16'h0500, 16'h0906, 16'h7E00, 2'b10, 9};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        hp_inA    = '0;
        hp_inB    = '0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(hp_product), 32'h0);
        chk("rst_exc", 32'(Exceptions), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            chk($sformatf("vec%0d_prod", i), 32'(hp_product), 32'(vecs[i].prod));
            chk($sformatf("vec%0d_exc", i), 32'(Exceptions), 32'(vecs[i].exc));
            consume();
            chk($sformatf("vec%0d_drop", i), 32'(out_valid), 32'd0);
        end

        // Backpressure then consume and accept on the same edge.
        start_op(16'h4500, 16'h4600, lat);
        chk("bp_lat", 32'(lat), 32'd9);
        held_prod = hp_product;
        stable = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (!out_valid || in_ready || !busy || hp_product !== held_prod || Exceptions !== 2'b00)
                stable = 1'b0;
        end
        chk("bp_stable", 32'(stable), 32'd1);
        chk("bp_prod", 32'(hp_product), 32'h4F80);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        hp_inA    = 16'h4200;
        hp_inB    = 16'h4200;
        #1;
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("b2b_gap", 32'(out_valid), 32'd0);
        chk("b2b_busy", 32'(busy), 32'd1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_lat", 32'(lat), 32'd9);
        chk("b2b_prod", 32'(hp_product), 32'h4880);
        consume();

        // Reset during the third BOOTH cycle.
        @(negedge clk);
        in_valid = 1'b1;
        hp_inA   = 16'h4500;
        hp_inB   = 16'h4600;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        stale = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid || busy) stale = 1'b1;
        end
        chk("post_rst_no_stale", 32'(stale), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
